// File: rtl/autoconfig_multi.sv
`default_nettype none
// ============================================================================
// Module      : autoconfig_multi
// Description : Zorro II AutoConfig responder that presents up to four logical
//               boards in turn behind a single CFGIN_n/CFGOUT_n slot position.
//               Each enabled board answers the $E8xxxx config space until it
//               is given a base address (write $48/$4A) or shut up (write $4C).
//               Once every board is done, CFGOUT_n is asserted and one address
//               decode select per configured board is produced.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK, RESET        bus clock, asynchronous active-high reset
//   ADDR[23:1]        68000 address bus
//   AS_n/UDS_n/RW     68000 strobes and direction
//   DIN[3:0]          write data D15:D12
//   CFGIN_n           chain enable from the previous slot
//   board_enable      per-board enable (static while out of reset)
//   CFGOUT_n          chain enable to the next slot
//   autoconfig_cycle  config access aimed at the board currently presented
//   DOUT[3:0]         registered read nibble for D15:D12
//   dtack             cycle acknowledge
//   board_select      address decode hit per configured board
//   cur_board         index of the board currently presented
// ============================================================================
module autoconfig_multi #(
    parameter int          NUM_BOARDS   = 2,
    parameter logic [15:0] MFG_ID       = 16'd5194,
    parameter logic [31:0] SERIAL       = 32'h0,
    parameter logic [7:0]  PROD_ID_BASE = 8'd7,
    parameter logic [11:0] BOARD_SIZE   = 12'h002,
    parameter logic [3:0]  BOARD_ROM    = 4'b0001,
    parameter logic [15:0] ROM_OFFSET   = 16'h0008
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [23:1]           ADDR,
    input  logic                  AS_n,
    input  logic                  UDS_n,
    input  logic                  RW,
    input  logic [3:0]            DIN,
    input  logic                  CFGIN_n,
    input  logic [NUM_BOARDS-1:0] board_enable,
    output logic                  CFGOUT_n,
    output logic                  autoconfig_cycle,
    output logic [3:0]            DOUT,
    output logic                  dtack,
    output logic [NUM_BOARDS-1:0] board_select,
    output logic [1:0]            cur_board
);

    typedef enum logic [1:0] {
        S_SKIP   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // Board index needs one extra bit so it can step past the last board.
    localparam logic [2:0] c_num_boards = 3'(NUM_BOARDS);

    state_t                      state_q, state_d;
    logic [2:0]                  board_q, board_d;
    logic [3:0]                  dout_q;
    logic                        dtack_q;
    logic                        as_n_q;
    logic [NUM_BOARDS-1:0]       configured_q;
    logic [NUM_BOARDS-1:0]       shutup_q;
    logic [NUM_BOARDS-1:0][7:0]  base_q;

    logic [7:0] w_reg;
    logic       w_rd_qual;
    logic       w_wr_qual;
    logic [3:0] w_rd;
    logic       w_cur_en;
    logic       w_cur_rom;
    logic [2:0] w_cur_size;
    logic [7:0] w_cur_prod;
    logic       w_cur_link;
    logic       w_cur_cfg;
    logic       w_cur_shut;
    logic       w_unused;

    // Number of address bits A23.. that a board of this size decodes.
    function automatic logic [7:0] size_mask(input logic [2:0] code);
        case (code)
            3'b000:  size_mask = 8'h80;
            3'b001:  size_mask = 8'hFF;
            3'b010:  size_mask = 8'hFE;
            3'b011:  size_mask = 8'hFC;
            3'b100:  size_mask = 8'hF8;
            3'b101:  size_mask = 8'hF0;
            3'b110:  size_mask = 8'hE0;
            default: size_mask = 8'hC0;
        endcase
    endfunction

    assign w_reg            = ADDR[8:1];
    assign w_unused         = &{1'b0, ADDR[15:9]};
    assign autoconfig_cycle = (ADDR[23:16] == 8'hE8) && !CFGIN_n && (state_q == S_ACTIVE);
    assign w_rd_qual        = RW && !AS_n && autoconfig_cycle;
    // Writes act only on the first qualified edge of a bus cycle.
    assign w_wr_qual        = !RW && !AS_n && !UDS_n && autoconfig_cycle && !dtack_q;

    // Attributes of the board currently presented.
    always_comb begin
        w_cur_en   = 1'b0;
        w_cur_rom  = 1'b0;
        w_cur_size = 3'b000;
        w_cur_prod = 8'h00;
        w_cur_link = 1'b0;
        w_cur_cfg  = 1'b0;
        w_cur_shut = 1'b0;
        for (int i = 0; i < NUM_BOARDS; i++) begin
            if (board_q == 3'(i)) begin
                w_cur_en   = board_enable[i];
                w_cur_rom  = BOARD_ROM[i];
                w_cur_size = BOARD_SIZE[3*i +: 3];
                w_cur_prod = PROD_ID_BASE + 8'(i);
                w_cur_cfg  = configured_q[i];
                w_cur_shut = shutup_q[i];
                for (int j = 0; j < NUM_BOARDS; j++) begin
                    if (j > i) begin
                        w_cur_link = w_cur_link | board_enable[j];
                    end
                end
            end
        end
    end

    // Config space read mux; most registers are returned inverted.
    always_comb begin
        w_rd = 4'hF;
        case (w_reg)
            8'h00: w_rd = {2'b11, 1'b0, w_cur_rom};
            8'h01: w_rd = {w_cur_link, w_cur_size};
            8'h02: w_rd = ~w_cur_prod[7:4];
            8'h03: w_rd = ~w_cur_prod[3:0];
            8'h04: w_rd = 4'hF;
            8'h05: w_rd = 4'hF;
            8'h08: w_rd = ~MFG_ID[15:12];
            8'h09: w_rd = ~MFG_ID[11:8];
            8'h0A: w_rd = ~MFG_ID[7:4];
            8'h0B: w_rd = ~MFG_ID[3:0];
            8'h0C: w_rd = ~SERIAL[31:28];
            8'h0D: w_rd = ~SERIAL[27:24];
            8'h0E: w_rd = ~SERIAL[23:20];
            8'h0F: w_rd = ~SERIAL[19:16];
            8'h10: w_rd = ~SERIAL[15:12];
            8'h11: w_rd = ~SERIAL[11:8];
            8'h12: w_rd = ~SERIAL[7:4];
            8'h13: w_rd = ~SERIAL[3:0];
            8'h14: w_rd = w_cur_rom ? ~ROM_OFFSET[15:12] : 4'hF;
            8'h15: w_rd = w_cur_rom ? ~ROM_OFFSET[11:8]  : 4'hF;
            8'h16: w_rd = w_cur_rom ? ~ROM_OFFSET[7:4]   : 4'hF;
            8'h17: w_rd = w_cur_rom ? ~ROM_OFFSET[3:0]   : 4'hF;
            8'h20: w_rd = 4'h0;
            8'h21: w_rd = 4'h0;
            default: w_rd = 4'hF;
        endcase
    end

    // Presentation sequencer.
    always_comb begin
        state_d = state_q;
        board_d = board_q;
        case (state_q)
            S_SKIP: begin
                if (board_q >= c_num_boards) begin
                    state_d = S_DONE;
                end else if (w_cur_en) begin
                    state_d = S_ACTIVE;
                end else begin
                    board_d = board_q + 3'd1;
                end
            end
            S_ACTIVE: begin
                // Move on only once the configuring bus cycle has ended.
                if (AS_n && !as_n_q && (w_cur_cfg || w_cur_shut)) begin
                    board_d = board_q + 3'd1;
                    state_d = S_SKIP;
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_SKIP;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= S_SKIP;
            board_q      <= 3'd0;
            dout_q       <= 4'h0;
            dtack_q      <= 1'b0;
            as_n_q       <= 1'b1;
            configured_q <= '0;
            shutup_q     <= '0;
            base_q       <= '0;
        end else begin
            state_q <= state_d;
            board_q <= board_d;
            as_n_q  <= AS_n;
            if (AS_n) begin
                dtack_q <= 1'b0;
            end else if (w_rd_qual || w_wr_qual) begin
                dtack_q <= 1'b1;
            end
            if (w_rd_qual) begin
                dout_q <= w_rd;
            end
            if (w_wr_qual) begin
                for (int i = 0; i < NUM_BOARDS; i++) begin
                    if (board_q == 3'(i)) begin
                        case (w_reg)
                            8'h25: begin
                                if (!configured_q[i]) begin
                                    base_q[i][3:0] <= DIN;
                                end
                            end
                            8'h24: begin
                                if (!configured_q[i]) begin
                                    base_q[i][7:4]  <= DIN;
                                    configured_q[i] <= 1'b1;
                                end
                            end
                            8'h26:   shutup_q[i] <= 1'b1;
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_BOARDS; gi++) begin : g_sel
            localparam logic [7:0] c_mask = size_mask(BOARD_SIZE[3*gi +: 3]);
            assign board_select[gi] = configured_q[gi] && !AS_n &&
                                      ((ADDR[23:16] & c_mask) == (base_q[gi] & c_mask));
        end
    endgenerate

    assign CFGOUT_n  = (state_q != S_DONE);
    assign DOUT      = dout_q;
    assign dtack     = dtack_q;
    assign cur_board = board_q[1:0];

endmodule
`default_nettype wire

// File: tb/tb_autoconfig_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_autoconfig_multi
// Description : Self-checking bench for autoconfig_multi (two boards, default
//               parameters). Table of config-space reads plus directed
//               sequences for configure, shut-up, skipping and mid-cycle reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_autoconfig_multi;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [23:1] ADDR = '0;
    logic        AS_n = 1'b1;
    logic        UDS_n = 1'b1;
    logic        RW = 1'b1;
    logic [3:0]  DIN = 4'h0;
    logic        CFGIN_n = 1'b0;
    logic [1:0]  board_enable = 2'b11;
    logic        CFGOUT_n;
    logic        autoconfig_cycle;
    logic [3:0]  DOUT;
    logic        dtack;
    logic [1:0]  board_select;
    logic [1:0]  cur_board;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [7:0] off;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[19];

    autoconfig_multi dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .ADDR             (ADDR),
        .AS_n             (AS_n),
        .UDS_n            (UDS_n),
        .RW               (RW),
        .DIN              (DIN),
        .CFGIN_n          (CFGIN_n),
        .board_enable     (board_enable),
        .CFGOUT_n         (CFGOUT_n),
        .autoconfig_cycle (autoconfig_cycle),
        .DOUT             (DOUT),
        .dtack            (dtack),
        .board_select     (board_select),
        .cur_board        (cur_board)
    );

    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [23:1] cfg_addr(input logic [7:0] off);
        cfg_addr = {8'hE8, 7'h00, off};
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1; AS_n = 1'b1; UDS_n = 1'b1; RW = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic bus_read(input logic [23:1] a, output logic [3:0] d, output logic ok);
        @(negedge CLK);
        ADDR = a; RW = 1'b1; UDS_n = 1'b0; AS_n = 1'b0;
        ok = 1'b0; d = 4'h0;
        for (int k = 0; k < 6 && !ok; k++) begin
            @(posedge CLK); #1;
            if (dtack) begin ok = 1'b1; d = DOUT; end
        end
        @(negedge CLK);
        AS_n = 1'b1; UDS_n = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic bus_write(input logic [7:0] off, input logic [3:0] data, output logic ok);
        @(negedge CLK);
        ADDR = cfg_addr(off); RW = 1'b0; DIN = data; UDS_n = 1'b0; AS_n = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 6 && !ok; k++) begin
            @(posedge CLK); #1;
            if (dtack) ok = 1'b1;
        end
        @(negedge CLK);
        AS_n = 1'b1; UDS_n = 1'b1; RW = 1'b1;
        @(posedge CLK); #1;
    endtask

    initial begin
        logic [3:0] d;
        logic       ok;

        // Board 0 register image: ROM, 128K, product 7, MFG $144A, serial 0.
        vecs[0]  = '{8'h00, 4'hD}; vecs[1]  = '{8'h01, 4'hA};
        vecs[2]  = '{8'h02, 4'hF}; vecs[3]  = '{8'h03, 4'h8};
        vecs[4]  = '{8'h04, 4'hF}; vecs[5]  = '{8'h05, 4'hF};
        vecs[6]  = '{8'h08, 4'hE}; vecs[7]  = '{8'h09, 4'hB};
        vecs[8]  = '{8'h0A, 4'hB}; vecs[9]  = '{8'h0B, 4'h5};
        vecs[10] = '{8'h0C, 4'hF}; vecs[11] = '{8'h13, 4'hF};
        vecs[12] = '{8'h14, 4'hF}; vecs[13] = '{8'h16, 4'hF};
        vecs[14] = '{8'h17, 4'h7}; vecs[15] = '{8'h20, 4'h0};
        vecs[16] = '{8'h21, 4'h0}; vecs[17] = '{8'h30, 4'hF};
        vecs[18] = '{8'h06, 4'hF};

        // Reset values while RESET is held.
        ADDR = cfg_addr(8'h00);
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_dout", DOUT, 4'h0);
        chk("rst_dtack", dtack, 1'b0);
        chk("rst_cfgout", CFGOUT_n, 1'b1);
        chk("rst_cur_board", cur_board, 2'd0);
        chk("rst_select", board_select, 2'b00);
        chk("rst_acycle", autoconfig_cycle, 1'b0);

        @(negedge CLK);
        RESET = 1'b0;

        for (int v = 0; v < 19; v++) begin
            bus_read(cfg_addr(vecs[v].off), d, ok);
            chk($sformatf("b0_ack_%02h", vecs[v].off), ok, 1'b1);
            chk($sformatf("b0_rd_%02h", vecs[v].off), d, vecs[v].exp);
        end

        // Configure board 0 at $E9xxxx.
        bus_write(8'h25, 4'h9, ok);
        chk("wr25_ack", ok, 1'b1);
        chk("b0_stays", cur_board, 2'd0);
        bus_write(8'h24, 4'hE, ok);
        chk("wr24_ack", ok, 1'b1);
        chk("advance_b1", cur_board, 2'd1);
        chk("adv_cfgout", CFGOUT_n, 1'b1);

        // Board 1: no ROM, 8M code, last board so no link.
        bus_read(cfg_addr(8'h01), d, ok);
        chk("b1_rd01_ack", ok, 1'b1);
        chk("b1_rd01", d, 4'h0);
        bus_read(cfg_addr(8'h00), d, ok);
        chk("b1_rd00", d, 4'hC);
        bus_read(cfg_addr(8'h03), d, ok);
        chk("b1_rd03", d, 4'h7);

        // Decode of configured board 0 (128K at $E80000-$E9FFFF).
        @(negedge CLK);
        ADDR = {8'hE9, 15'h0}; RW = 1'b1; AS_n = 1'b0;
        #1 chk("sel_E9", board_select, 2'b01);
        ADDR = {8'hEA, 15'h0};
        #1 chk("sel_EA", board_select, 2'b00);
        AS_n = 1'b1;
        ADDR = {8'hE9, 15'h0};
        #1 chk("sel_E9_noas", board_select, 2'b00);
        @(posedge CLK); #1;

        // Shut board 1 up; chain should open within two clocks of AS_n rising.
        bus_write(8'h26, 4'h0, ok);
        chk("wr26_ack", ok, 1'b1);
        @(posedge CLK); #1;
        chk("shut_cfgout", CFGOUT_n, 1'b0);
        bus_read(cfg_addr(8'h00), d, ok);
        chk("done_no_dtack", ok, 1'b0);
        @(negedge CLK);
        ADDR = '0; AS_n = 1'b0;
        #1 chk("shut_no_sel", board_select[1], 1'b0);
        AS_n = 1'b1;

        // Mid-cycle reset after board 0 configured.
        do_reset();
        bus_write(8'h25, 4'h9, ok);
        bus_write(8'h24, 4'hE, ok);
        chk("re_cfg_b1", cur_board, 2'd1);
        @(negedge CLK);
        ADDR = cfg_addr(8'h00); RW = 1'b1; UDS_n = 1'b0; AS_n = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 6 && !ok; k++) begin
            @(posedge CLK); #1;
            if (dtack) ok = 1'b1;
        end
        chk("mid_dtack_up", ok, 1'b1);
        chk("mid_sel_before", board_select, 2'b01);
        #2 RESET = 1'b1;
        #1;
        chk("mid_dtack", dtack, 1'b0);
        chk("mid_dout", DOUT, 4'h0);
        chk("mid_sel", board_select, 2'b00);
        chk("mid_cur", cur_board, 2'd0);
        chk("mid_cfgout", CFGOUT_n, 1'b1);
        @(negedge CLK);
        AS_n = 1'b1; UDS_n = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        bus_read(cfg_addr(8'h00), d, ok);
        chk("rerun_ack", ok, 1'b1);
        chk("rerun_rd00", d, 4'hD);

        // Only board 1 enabled: first presented board is product 8.
        @(negedge CLK);
        RESET = 1'b1;
        board_enable = 2'b10;
        do_reset();
        bus_read(cfg_addr(8'h02), d, ok);
        chk("en10_rd02", d, 4'hF);
        chk("en10_cur", cur_board, 2'd1);
        bus_read(cfg_addr(8'h03), d, ok);
        chk("en10_rd03", d, 4'h7);
        bus_read(cfg_addr(8'h01), d, ok);
        chk("en10_rd01", d, 4'h0);

        // No boards enabled: chain opens three clocks after reset.
        @(negedge CLK);
        RESET = 1'b1;
        board_enable = 2'b00;
        do_reset();
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("en00_cfgout_2clk", CFGOUT_n, 1'b1);
        @(posedge CLK); #1;
        chk("en00_cfgout_3clk", CFGOUT_n, 1'b0);
        bus_read(cfg_addr(8'h00), d, ok);
        chk("en00_no_dtack", ok, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
